// File: rtl/ahb_params_pkg.sv
// AHB-Lite signal encodings shared by the AHB slaves in this subsystem.
package ahb_params_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SizeByte   = 3'd0,
        SizeHalf   = 3'd1,
        SizeWord   = 3'd2,
        SizeDword  = 3'd3,
        Size4Word  = 3'd4,
        Size8Word  = 3'd5,
        Size16Word = 3'd6,
        Size32Word = 3'd7
    } hsize_t;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } hresp_t;

endpackage

// File: rtl/apb_params_pkg.sv
// Bridge state encoding and default APB peripheral map geometry.
package apb_params_pkg;

    localparam int unsigned NO_OF_APB_SLAVES = 4;
    localparam int unsigned PSEL_LSB         = 12;

    typedef enum logic [2:0] {
        StIdle,
        StWwait,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } bridge_state_t;

endpackage

// File: rtl/apb_slave_decoder.sv
// Peripheral index to one-hot PSEL; flags indices with no peripheral behind them.
module apb_slave_decoder #(
    parameter int unsigned NO_OF_APB_SLAVES = 4,
    parameter int unsigned IDX_W            = 3
) (
    input  logic [IDX_W-1:0]            index_i,
    output logic [NO_OF_APB_SLAVES-1:0] psel_o,
    output logic                        illegal_o
);

    always_comb begin
        psel_o    = '0;
        illegal_o = 1'b1;
        for (int unsigned i = 0; i < NO_OF_APB_SLAVES; i++) begin
            if (index_i == IDX_W'(i)) begin
                psel_o[i] = 1'b1;
                illegal_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave that turns each single transfer into one APB SETUP/ACCESS sequence.
module ahb_apb_bridge
    import ahb_params_pkg::*;
    import apb_params_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned NO_OF_APB_SLAVES = apb_params_pkg::NO_OF_APB_SLAVES,
    parameter int unsigned PSEL_LSB         = apb_params_pkg::PSEL_LSB
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        HSEL_APB,
    input  logic [ADDR_WIDTH-1:0]       HADDR,
    input  htrans_t                     HTRANS,
    input  logic                        HWRITE,
    input  hsize_t                      HSIZE,
    input  logic [DATA_WIDTH-1:0]       HWDATA,
    input  logic                        HREADY,
    output logic [DATA_WIDTH-1:0]       HRDATA_APB,
    output logic                        HREADYOUT,
    output hresp_t                      HRESP_APB,
    output logic [ADDR_WIDTH-1:0]       PADDR,
    output logic [NO_OF_APB_SLAVES-1:0] PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [DATA_WIDTH-1:0]       PWDATA,
    input  logic [DATA_WIDTH-1:0]       PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    // One bit wider than strictly needed so an out-of-range peripheral number is visible.
    localparam int unsigned IDX_W = $clog2(NO_OF_APB_SLAVES) + 1;

    bridge_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]       paddr_q, paddr_d;
    logic [NO_OF_APB_SLAVES-1:0] sel_q, sel_d;
    logic [NO_OF_APB_SLAVES-1:0] psel_q, psel_d;
    logic                        pwrite_q, pwrite_d;
    logic                        penable_q, penable_d;
    logic                        hreadyout_q, hreadyout_d;
    logic [DATA_WIDTH-1:0]       pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0]       hrdata_q, hrdata_d;
    hresp_t                      hresp_q, hresp_d;

    logic [IDX_W-1:0]            haddr_idx;
    logic [NO_OF_APB_SLAVES-1:0] dec_psel;
    logic                        dec_illegal;
    logic                        bad_size;
    logic                        illegal;
    logic                        accept;

    assign haddr_idx = HADDR[PSEL_LSB +: IDX_W];

    apb_slave_decoder #(
        .NO_OF_APB_SLAVES(NO_OF_APB_SLAVES),
        .IDX_W           (IDX_W)
    ) u_decoder (
        .index_i  (haddr_idx),
        .psel_o   (dec_psel),
        .illegal_o(dec_illegal)
    );

    // APB has no strobes here, so anything wider than a word or misaligned is refused.
    always_comb begin
        case (HSIZE)
            SizeByte: bad_size = 1'b0;
            SizeHalf: bad_size = HADDR[0];
            SizeWord: bad_size = |HADDR[1:0];
            default:  bad_size = 1'b1;
        endcase
    end

    assign illegal = dec_illegal | bad_size;
    assign accept  = HSEL_APB & HREADY
                   & ((HTRANS == TransNonseq) | (HTRANS == TransSeq))
                   & ((state_q == StIdle) | (state_q == StErr2));

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        sel_d    = sel_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;

        case (state_q)
            StIdle, StErr2: begin
                state_d = StIdle;
                if (accept) begin
                    if (illegal) begin
                        state_d = StErr1;
                    end else begin
                        state_d  = HWRITE ? StWwait : StSetup;
                        paddr_d  = HADDR;
                        pwrite_d = HWRITE;
                        sel_d    = dec_psel;
                    end
                end
            end
            StWwait: begin
                pwdata_d = HWDATA;
                state_d  = StSetup;
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_d = StErr1;
                    end else begin
                        state_d = StIdle;
                        if (!pwrite_q) hrdata_d = PRDATA;
                    end
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so every port comes straight from a flop.
        psel_d      = ((state_d == StSetup) || (state_d == StAccess)) ? sel_d : '0;
        penable_d   = (state_d == StAccess);
        hreadyout_d = !((state_d == StWwait) || (state_d == StSetup) ||
                        (state_d == StAccess) || (state_d == StErr1));
        hresp_d     = ((state_d == StErr1) || (state_d == StErr2)) ? RespError : RespOkay;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            sel_q       <= '0;
            psel_q      <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hresp_q     <= RespOkay;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            sel_q       <= sel_d;
            psel_q      <= psel_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hresp_q     <= hresp_d;
        end
    end

    assign HRDATA_APB = hrdata_q;
    assign HREADYOUT  = hreadyout_q;
    assign HRESP_APB  = hresp_q;
    assign PADDR      = paddr_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PWDATA     = pwdata_q;

endmodule
